// File: rtl/ctrl_bubble_pipe_reg.sv
// ID/EX control-word pipeline register with bubble insertion, stall hold,
// flush clear, a ready/busy handshake and a saturating bubble counter.
module ctrl_bubble_pipe_reg #(
  parameter int unsigned WIDTH = 23,
  parameter int unsigned LEN_W = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_ctrl,
  input  logic             in_valid,
  input  logic             nop_req,
  input  logic [LEN_W-1:0] nop_len,
  input  logic             stall,
  input  logic             flush,
  output logic [WIDTH-1:0] out_ctrl,
  output logic             out_valid,
  output logic             in_ready,
  output logic             busy,
  output logic [CNT_W-1:0] bubble_count
);

  typedef enum logic {
    IDLE   = 1'b0,
    BUBBLE = 1'b1
  } state_t;

  state_t           state_q,  state_d;
  logic [LEN_W-1:0] remain_q, remain_d;
  logic [WIDTH-1:0] ctrl_q,   ctrl_d;
  logic             valid_q,  valid_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;

  logic [LEN_W-1:0] eff_len;
  logic [CNT_W-1:0] cnt_inc;

  // A zero length request still produces one bubble.
  assign eff_len = (nop_len == '0) ? LEN_W'(1) : nop_len;

  // Counter sticks at all-ones instead of wrapping.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  // Next-state selection in priority order: flush, stall, bubble, load.
  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    ctrl_d   = ctrl_q;
    valid_d  = valid_q;
    cnt_d    = cnt_q;
    if (flush) begin
      state_d  = IDLE;
      remain_d = '0;
      ctrl_d   = '0;
      valid_d  = 1'b0;
    end else if (stall) begin
      // hold everything
    end else if (state_q == BUBBLE) begin
      ctrl_d  = '0;
      valid_d = 1'b0;
      cnt_d   = cnt_inc;
      if (remain_q == LEN_W'(1)) begin
        state_d  = IDLE;
        remain_d = '0;
      end else begin
        remain_d = remain_q - LEN_W'(1);
      end
    end else if (nop_req) begin
      ctrl_d  = '0;
      valid_d = 1'b0;
      cnt_d   = cnt_inc;
      if (eff_len > LEN_W'(1)) begin
        state_d  = BUBBLE;
        remain_d = eff_len - LEN_W'(1);
      end
    end else begin
      ctrl_d  = in_ctrl;
      valid_d = in_valid;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      remain_q <= '0;
      ctrl_q   <= '0;
      valid_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      ctrl_q   <= ctrl_d;
      valid_q  <= valid_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready     = reset_n & ~flush & ~stall & (state_q == IDLE) & ~nop_req;
  assign busy         = (state_q == BUBBLE);
  assign out_ctrl     = ctrl_q;
  assign out_valid    = valid_q;
  assign bubble_count = cnt_q;

endmodule

// File: doc/ctrl_bubble_pipe_reg.md
Name: ctrl_bubble_pipe_reg

Overview:
- Parametrised ID/EX control-signal pipeline register. It is the clocked successor of the combinational NOP mux.
- It registers the decoded control word each cycle. It can insert single or multi-cycle bubbles (zeroed control word), hold on stall, and clear on flush.
- It exposes a ready/busy handshake toward the hazard unit and a saturating bubble counter for performance checks.
- It sits between the control unit / ID stage and the EX stage.

Parameters:
- WIDTH, 23, width of the control word.
- LEN_W, 2, width of nop_len; max multi-cycle bubble run is 2^LEN_W-1.
- CNT_W, 8, width of the bubble_count performance counter.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- in_ctrl  input  WIDTH  decoded control word from the ID stage.
- in_valid  input  1  in_ctrl carries a real instruction.
- nop_req  input  1  request a bubble run starting this cycle.
- nop_len  input  LEN_W  length of the requested bubble run; 0 is treated as 1.
- stall  input  1  hold all state.
- flush  input  1  clear the stage (branch/exception squash).
- out_ctrl  output  WIDTH  registered control word to EX.
- out_valid  output  1  out_ctrl is a real instruction.
- in_ready  output  1  in_ctrl is captured at the next edge (combinational).
- busy  output  1  multi-cycle bubble run in progress (registered state).
- bubble_count  output  CNT_W  saturating count of bubbles inserted.

Behaviour:
- Clocking: one clock; reset is synchronous and active-low.
- Reset (reset_n=0 at edge):
  - out_ctrl=0, out_valid=0, bubble_count=0.
  - state=IDLE, remain=0, busy=0.
- FSM states: IDLE, BUBBLE. Internal down-counter remain is LEN_W bits. Let eff_len = (nop_len==0) ? 1 : nop_len.
- Per-edge priority: reset > flush > stall > bubble > load.
  - flush=1: out_ctrl=0, out_valid=0, state->IDLE, remain=0. bubble_count is unchanged; a flush is not a bubble.
  - stall=1 (no flush): out_ctrl, out_valid, state, remain and bubble_count all hold.
  - IDLE and nop_req=1:
    - out_ctrl=0, out_valid=0, bubble_count+=1.
    - If eff_len>1: state->BUBBLE, remain=eff_len-1. Otherwise stay in IDLE.
    - in_ctrl is not captured.
  - BUBBLE:
    - out_ctrl=0, out_valid=0, bubble_count+=1.
    - If remain==1: state->IDLE, remain=0. Otherwise remain-=1.
    - nop_req and nop_len are ignored.
  - IDLE, no nop_req: out_ctrl=in_ctrl, out_valid=in_valid.
- in_ready = reset_n & ~flush & ~stall & (state==IDLE) & ~nop_req.
- busy = (state==BUBBLE).
- bubble_count saturates at 2^CNT_W-1 and never wraps.
- Latency: exactly 1 cycle from in_ctrl to out_ctrl when in_ready=1.
- A bubble of eff_len N occupies exactly N consecutive non-stalled edges. Stall edges inside the run extend it without consuming remain.
- Flush mid-run aborts the run. The next edge behaves as IDLE.
- Reset mid-run aborts the run the same way, and also clears the counter.
- nop_req and flush together: flush wins, no bubble is counted.
- nop_req and stall together: nothing happens. The request must be held until stall drops.

Test Plan (WIDTH=23, LEN_W=2, CNT_W=8):
- Reset then load: reset_n=0 for 2 edges, then in_ctrl=23'h5A5A5A, in_valid=1 -> out_ctrl=0 and out_valid=0 during reset; out_ctrl=23'h5A5A5A and out_valid=1 one edge later; in_ready=1.
- Single bubble: IDLE, nop_req=1, nop_len=0, in_ctrl=23'h7FFFFF -> in_ready=0; next edge out_ctrl=0, out_valid=0, busy=0, bubble_count=1.
- Multi-cycle run: nop_req=1 and nop_len=3 for one edge, in_ctrl=23'h000123 held -> 3 edges of out_ctrl=0 with busy=1 after edges 1 and 2; bubble_count=3; fourth edge out_ctrl=23'h000123.
- Stall inside run: nop_len=3, stall=1 on the 2nd edge -> out holds 0, remain and count frozen; run ends after 4 edges total with bubble_count=3.
- Flush priority: busy=1 with remain=2, assert flush and nop_req together -> out_ctrl=0, out_valid=0, busy=0, bubble_count unchanged; next edge loads in_ctrl.
- Saturation: issue 300 single bubbles -> bubble_count reaches 8'hFF and stays there; load path is unaffected.
